// File: rtl/lc3_reg_file_pkg.sv
// Shared LC-3 constants: datapath width, register-file geometry and the
// N/Z/P condition-code encodings.
package lc3_reg_file_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int NUM_REGS  = 8;
   localparam int REG_IDX_W = 3;

   typedef logic [2:0] cc_t;

   localparam cc_t CC_N = 3'b100;
   localparam cc_t CC_Z = 3'b010;
   localparam cc_t CC_P = 3'b001;

endpackage

// File: rtl/lc3_reg_file_dec.sv
// 3-to-8 one-hot decoder. Enable gating is left to the caller.
module decoder_3_8
   import lc3_reg_file_pkg::*;
(
   input  logic [REG_IDX_W-1:0] sel_i,
   output logic [NUM_REGS-1:0]  dec_o
);

   // One bit per register, set at the selected index
   always_comb begin
      dec_o = '0;
      dec_o[sel_i] = 1'b1;
   end

endmodule

// File: rtl/lc3_reg_file.sv
// LC-3 general-purpose register file: R0..R7, two combinational read ports
// with same-cycle write forwarding, and the N/Z/P condition-code register.
module lc3_reg_file
   import lc3_reg_file_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ld_reg,
   input  logic [REG_IDX_W-1:0] dr,
   input  logic [WIDTH-1:0]     din,
   input  logic                 ld_cc,
   input  logic [REG_IDX_W-1:0] sr1,
   input  logic [REG_IDX_W-1:0] sr2,
   output logic [WIDTH-1:0]     sr1_out,
   output logic [WIDTH-1:0]     sr2_out,
   output logic                 n,
   output logic                 z,
   output logic                 p
);

   logic [NUM_REGS-1:0] dec;
   logic [NUM_REGS-1:0] we;
   logic [WIDTH-1:0]    regs_q [NUM_REGS];
   logic [WIDTH-1:0]    regs_d [NUM_REGS];
   cc_t                 cc_q, cc_d;
   cc_t                 cc_new;

   decoder_3_8 u_dec (
      .sel_i (dr),
      .dec_o (dec)
   );

   // Write enables: decoded destination qualified by the register load strobe
   always_comb begin
      we = dec & {NUM_REGS{ld_reg}};
   end

   // Array next state: enabled entry takes the write-back bus, others hold
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = we[i] ? din : regs_q[i];
      end
   end

   // Array state; reset wins over any write in the same cycle
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REGS; i++) begin
         if (reset) regs_q[i] <= '0;
         else       regs_q[i] <= regs_d[i];
      end
   end

   // Read ports: a write to the addressed register this cycle bypasses the array
   always_comb begin
      sr1_out = regs_q[sr1];
      sr2_out = regs_q[sr2];
      if (ld_reg && (dr == sr1)) sr1_out = din;
      if (ld_reg && (dr == sr2)) sr2_out = din;
   end

   // Sign/zero classification of the write-back value
   always_comb begin
      if (din[WIDTH-1])    cc_new = CC_N;
      else if (din == '0)  cc_new = CC_Z;
      else                 cc_new = CC_P;
      cc_d = ld_cc ? cc_new : cc_q;
   end

   // Condition-code register; reset leaves Z set so exactly one flag is high
   always_ff @(posedge clk) begin
      if (reset) cc_q <= CC_Z;
      else       cc_q <= cc_d;
   end

   // Flags come straight from state, no bypass
   always_comb begin
      {n, z, p} = cc_q;
   end

endmodule

// File: tb/tb_lc3_reg_file.sv
module tb_lc3_reg_file;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          reset, ld_reg, ld_cc;
   logic [2:0]    dr, sr1, sr2;
   logic [W-1:0]  din, sr1_out, sr2_out;
   logic          n, z, p;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: architectural state as plain arrays
   logic [W-1:0] m_regs [8];
   logic [2:0]   m_cc;

   always #5 clk = ~clk;

   lc3_reg_file #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset   (reset),
      .ld_reg  (ld_reg),
      .dr      (dr),
      .din     (din),
      .ld_cc   (ld_cc),
      .sr1     (sr1),
      .sr2     (sr2),
      .sr1_out (sr1_out),
      .sr2_out (sr2_out),
      .n       (n),
      .z       (z),
      .p       (p)
   );

   // Expected read value: a write in flight to that register is seen immediately
   function automatic logic [W-1:0] exp_rd(input logic [2:0] s);
      if (ld_reg && dr == s) return din;
      return m_regs[s];
   endfunction

   function automatic logic [2:0] flags_of(input logic [W-1:0] v);
      if ($signed(v) < 0) return 3'b100;
      if (v == 0)         return 3'b010;
      return 3'b001;
   endfunction

   // Advance one clock: model absorbs the inputs sampled at the edge,
   // then return at the falling edge ready for the next drive
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 8; i++) m_regs[i] = '0;
         m_cc = 3'b010;
      end else begin
         if (ld_reg) m_regs[dr] = din;
         if (ld_cc)  m_cc = flags_of(din);
      end
      @(negedge clk);
   endtask

   task automatic idle();
      reset = 0; ld_reg = 0; ld_cc = 0;
   endtask

   task automatic test_reset();
      reset = 1; ld_reg = 1; dr = 3; din = 16'h1234; ld_cc = 0; sr1 = 3; sr2 = 0;
      tick(); tick();
      idle(); sr1 = 3; sr2 = 3;
      #1;
      n_tests++;
      if (sr1_out !== 16'h0000) begin
         n_fail++; $display("FAIL reset_r3 got %h want 0000", sr1_out);
      end
      n_tests++;
      if ({n, z, p} !== 3'b010) begin
         n_fail++; $display("FAIL reset_cc got %b want 010", {n, z, p});
      end
      for (int i = 0; i < 8; i++) begin
         sr2 = 3'(i); #1;
         n_tests++;
         if (sr2_out !== 16'h0000) begin
            n_fail++; $display("FAIL reset_sweep r%0d got %h want 0000", i, sr2_out);
         end
      end
   endtask

   task automatic test_write_readback();
      for (int i = 0; i < 8; i++) begin
         ld_reg = 1; dr = 3'(i); din = 16'h1000 + 16'(i);
         tick();
      end
      idle();
      for (int i = 0; i < 8; i++) begin
         sr1 = 3'(i); sr2 = 3'(7 - i); #1;
         n_tests++;
         if (sr1_out !== 16'h1000 + 16'(i)) begin
            n_fail++; $display("FAIL readback_sr1 r%0d got %h want %h", i, sr1_out, 16'h1000 + 16'(i));
         end
         n_tests++;
         if (sr2_out !== 16'h1000 + 16'(7 - i)) begin
            n_fail++; $display("FAIL readback_sr2 r%0d got %h want %h", 7 - i, sr2_out, 16'h1000 + 16'(7 - i));
         end
      end
   endtask

   task automatic test_forwarding();
      ld_reg = 1; dr = 5; din = 16'hBEEF; sr1 = 5; sr2 = 5; #1;
      n_tests++;
      if (sr1_out !== 16'hBEEF) begin
         n_fail++; $display("FAIL fwd_sr1 got %h want BEEF", sr1_out);
      end
      n_tests++;
      if (sr2_out !== 16'hBEEF) begin
         n_fail++; $display("FAIL fwd_sr2 got %h want BEEF", sr2_out);
      end
      sr2 = 4; #1;
      n_tests++;
      if (sr2_out !== 16'h1004) begin
         n_fail++; $display("FAIL fwd_other got %h want 1004", sr2_out);
      end
      tick();
      idle(); sr1 = 5; #1;
      n_tests++;
      if (sr1_out !== 16'hBEEF) begin
         n_fail++; $display("FAIL fwd_stored got %h want BEEF", sr1_out);
      end
   endtask

   task automatic test_cc();
      logic [W-1:0] vals [4];
      logic         ens  [4];
      logic [2:0]   want [4];
      vals = '{16'h8000, 16'h0000, 16'h7FFF, 16'h8000};
      ens  = '{1'b1, 1'b1, 1'b1, 1'b0};
      want = '{3'b100, 3'b010, 3'b001, 3'b001};
      for (int i = 0; i < 4; i++) begin
         idle(); ld_cc = ens[i]; din = vals[i];
         tick();
         n_tests++;
         if ({n, z, p} !== want[i]) begin
            n_fail++; $display("FAIL cc_%0d din %h got %b want %b", i, vals[i], {n, z, p}, want[i]);
         end
      end
      idle();
   endtask

   task automatic test_independent();
      idle(); ld_cc = 1; din = 16'hFFFF; dr = 3'($urandom_range(0, 7));
      tick();
      idle();
      n_tests++;
      if ({n, z, p} !== 3'b100) begin
         n_fail++; $display("FAIL indep_cc got %b want 100", {n, z, p});
      end
      for (int i = 0; i < 8; i++) begin
         sr1 = 3'(i); #1;
         n_tests++;
         if (sr1_out !== m_regs[i]) begin
            n_fail++; $display("FAIL indep_regs r%0d got %h want %h", i, sr1_out, m_regs[i]);
         end
      end
      ld_reg = 1; dr = 6; din = 16'h0000;
      tick();
      idle(); sr1 = 6; #1;
      n_tests++;
      if ({n, z, p} !== 3'b100) begin
         n_fail++; $display("FAIL indep_hold got %b want 100", {n, z, p});
      end
      n_tests++;
      if (sr1_out !== 16'h0000) begin
         n_fail++; $display("FAIL indep_r6 got %h want 0000", sr1_out);
      end
   endtask

   task automatic test_reset_priority();
      idle(); ld_reg = 1; dr = 2; din = 16'h00AA;
      tick();
      reset = 1; ld_reg = 1; dr = 2; din = 16'h5555; ld_cc = 1; sr1 = 2; sr2 = 1; #1;
      n_tests++;
      if (sr1_out !== 16'h5555) begin
         n_fail++; $display("FAIL rstpri_fwd got %h want 5555", sr1_out);
      end
      tick();
      idle(); sr1 = 2; #1;
      n_tests++;
      if (sr1_out !== 16'h0000) begin
         n_fail++; $display("FAIL rstpri_r2 got %h want 0000", sr1_out);
      end
      n_tests++;
      if ({n, z, p} !== 3'b010) begin
         n_fail++; $display("FAIL rstpri_cc got %b want 010", {n, z, p});
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         reset  = ($urandom_range(0, 24) == 0);
         ld_reg = 1'($urandom);
         ld_cc  = 1'($urandom);
         dr     = 3'($urandom);
         sr1    = 3'($urandom);
         sr2    = ($urandom_range(0, 3) == 0) ? dr : 3'($urandom);
         case ($urandom_range(0, 3))
            0:       din = '0;
            1:       din = 16'h8000 | 16'($urandom);
            default: din = 16'($urandom);
         endcase
         #1;
         n_tests++;
         if (sr1_out !== exp_rd(sr1)) begin
            n_fail++; $display("FAIL rand_sr1 it%0d got %h want %h", k, sr1_out, exp_rd(sr1));
         end
         n_tests++;
         if (sr2_out !== exp_rd(sr2)) begin
            n_fail++; $display("FAIL rand_sr2 it%0d got %h want %h", k, sr2_out, exp_rd(sr2));
         end
         tick();
         n_tests++;
         if ({n, z, p} !== m_cc) begin
            n_fail++; $display("FAIL rand_cc it%0d got %b want %b", k, {n, z, p}, m_cc);
         end
      end
      idle();
   endtask

   initial begin
      idle(); dr = 0; din = 0; sr1 = 0; sr2 = 0;
      for (int i = 0; i < 8; i++) m_regs[i] = 'x;
      m_cc = 'x;
      @(negedge clk);
      test_reset();
      test_write_readback();
      test_forwarding();
      test_cc();
      test_independent();
      test_reset_priority();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
